lru_ctrl: RTL and testbench

LRU_CTRL -- requirements
Module: lru_ctrl

---
 rtl/lru_ctrl.sv | 144 ++++++++++++++
 tb/tb_lru_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/lru_ctrl.sv
// 1-bit LRU controller for a 2-way set-associative cache.
// Clears the LRU table after reset, then serves one lookup/update per 4 cycles.
module lru_ctrl #(
    parameter int INDEX_AW = 8,
    parameter int DEPTH    = 256
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic [INDEX_AW-1:0] req_index_i,
    input  logic                req_hit_i,
    input  logic                req_hit_way_i,
    output logic                resp_valid_o,
    output logic                resp_way_o,
    output logic                init_done_o,
    output logic [INDEX_AW-1:0] lru_index_o,
    output logic                lru_wr_en_o,
    output logic                lru_wr_lru_o,
    input  logic                lru_rd_i
);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_READ,
        S_RESOLVE,
        S_WRITE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [INDEX_AW-1:0] r_cnt;
    logic [INDEX_AW-1:0] r_index;
    logic                r_hit;
    logic                r_hit_way;
    logic                r_way;
    logic                r_new_bit;
    logic                r_init_done;

    logic w_cnt_last;
    logic w_accept;
    logic w_way;

    assign w_cnt_last  = (r_cnt == INDEX_AW'(DEPTH - 1));
    assign w_accept    = req_valid_i && (r_state == S_IDLE);
    assign w_way       = r_hit ? r_hit_way : lru_rd_i;
    assign init_done_o = r_init_done;

    // State register; reset always restarts the clear sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_INIT;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and all outputs, decoded from registered state and data.
    always_comb begin
        w_next       = r_state;
        req_ready_o  = 1'b0;
        resp_valid_o = 1'b0;
        resp_way_o   = 1'b0;
        lru_index_o  = r_index;
        lru_wr_en_o  = 1'b0;
        lru_wr_lru_o = 1'b0;
        unique case (r_state)
            S_INIT: begin
                lru_index_o = r_cnt;
                lru_wr_en_o = 1'b1;
                if (w_cnt_last) begin
                    w_next = S_IDLE;
                end
            end
            S_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    w_next = S_READ;
                end
            end
            S_READ: begin
                w_next = S_RESOLVE;
            end
            S_RESOLVE: begin
                w_next = S_WRITE;
            end
            S_WRITE: begin
                lru_wr_en_o  = 1'b1;
                lru_wr_lru_o = r_new_bit;
                resp_valid_o = 1'b1;
                resp_way_o   = r_way;
                w_next       = S_IDLE;
            end
            default: begin
                w_next = S_INIT;
            end
        endcase
    end

    // Clear-sweep counter; holds at the last entry so it never overruns.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_state == S_INIT && !w_cnt_last) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Sweep-complete flag, sticky until the next reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_init_done <= 1'b0;
        end else if (r_state == S_INIT && w_cnt_last) begin
            r_init_done <= 1'b1;
        end
    end

    // Request capture; inputs are ignored while a request is in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_index   <= '0;
            r_hit     <= 1'b0;
            r_hit_way <= 1'b0;
        end else if (w_accept) begin
            r_index   <= req_index_i;
            r_hit     <= req_hit_i;
            r_hit_way <= req_hit_way_i;
        end
    end

    // Resolve accessed way; the other way becomes least recently used.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_way     <= 1'b0;
            r_new_bit <= 1'b0;
        end else if (r_state == S_RESOLVE) begin
            r_way     <= w_way;
            r_new_bit <= ~w_way;
        end
    end

endmodule

// File: tb/tb_lru_ctrl.sv
// Bench for lru_ctrl: 1-bit table harness plus a per-set victim model.
// Directed cases first, then randomized requests and a mid-request reset.
module tb_lru_ctrl;

    localparam int AW    = 8;
    localparam int DEPTH = 256;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid_i;
    logic          req_ready_o;
    logic [AW-1:0] req_index_i;
    logic          req_hit_i;
    logic          req_hit_way_i;
    logic          resp_valid_o;
    logic          resp_way_o;
    logic          init_done_o;
    logic [AW-1:0] lru_index_o;
    logic          lru_wr_en_o;
    logic          lru_wr_lru_o;
    logic          lru_rd_i;

    logic          mem [DEPTH];
    bit            ref_lru [DEPTH];

    int n_vec = 0;
    int n_err = 0;

    lru_ctrl #(.INDEX_AW(AW), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_index_i   (req_index_i),
        .req_hit_i     (req_hit_i),
        .req_hit_way_i (req_hit_way_i),
        .resp_valid_o  (resp_valid_o),
        .resp_way_o    (resp_way_o),
        .init_done_o   (init_done_o),
        .lru_index_o   (lru_index_o),
        .lru_wr_en_o   (lru_wr_en_o),
        .lru_wr_lru_o  (lru_wr_lru_o),
        .lru_rd_i      (lru_rd_i)
    );

    always #5 clk = ~clk;

    // Synchronous 1-bit table with registered read data.
    always @(posedge clk) begin
        if (lru_wr_en_o) mem[lru_index_o] <= lru_wr_lru_o;
        lru_rd_i <= mem[lru_index_o];
    end

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic init_sweep();
        for (int i = 0; i < DEPTH; i++) begin
            check("init",
                  {req_ready_o, init_done_o, lru_wr_en_o,
                   lru_wr_lru_o, resp_valid_o, lru_index_o},
                  {5'b00100, i[7:0]});
            @(negedge clk);
        end
        check("init_done", {init_done_o, req_ready_o}, 2'b11);
        for (int k = 0; k < DEPTH; k++) ref_lru[k] = 1'b0;
    endtask

    task automatic scramble();
        req_valid_i   = 1'($urandom);
        req_index_i   = 8'($urandom);
        req_hit_i     = 1'($urandom);
        req_hit_way_i = 1'($urandom);
    endtask

    task automatic do_req(input logic [AW-1:0] idx, input logic hit,
                          input logic way, input bit hold);
        int   t;
        logic ew;
        logic nb;
        t = 0;
        while (!req_ready_o && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("ready", {31'd0, req_ready_o}, 1);
        if (!req_ready_o) return;
        check("idle_out", {resp_valid_o, lru_wr_en_o, init_done_o}, 3'b001);
        req_valid_i   = 1'b1;
        req_index_i   = idx;
        req_hit_i     = hit;
        req_hit_way_i = way;
        @(negedge clk);
        if (!hold) scramble();
        check("read",
              {req_ready_o, resp_valid_o, lru_wr_en_o, lru_index_o},
              {3'b000, idx});
        @(negedge clk);
        if (!hold) scramble();
        check("resolve", {req_ready_o, resp_valid_o, lru_wr_en_o}, 3'b000);
        @(negedge clk);
        if (!hold) req_valid_i = 1'b0;
        ew = hit ? way : logic'(ref_lru[idx]);
        nb = ~ew;
        ref_lru[idx] = nb;
        check("write",
              {req_ready_o, resp_valid_o, lru_wr_en_o,
               resp_way_o, lru_wr_lru_o, lru_index_o},
              {3'b011, ew, nb, idx});
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst           = 1'b1;
        req_valid_i   = 1'b0;
        req_index_i   = '0;
        req_hit_i     = 1'b0;
        req_hit_way_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("reset_out",
              {req_ready_o, resp_valid_o, resp_way_o, init_done_o,
               lru_wr_en_o, lru_wr_lru_o, lru_index_o},
              {6'b000010, 8'h00});
        rst = 1'b0;
        init_sweep();

        do_req(8'h12, 1'b0, 1'b0, 1'b0);
        do_req(8'h12, 1'b1, 1'b0, 1'b0);
        do_req(8'h12, 1'b0, 1'b0, 1'b0);

        do_req(8'hFF, 1'b0, 1'b0, 1'b0);
        do_req(8'hFF, 1'b0, 1'b0, 1'b0);
        do_req(8'hFF, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 3; i++) do_req(8'h33, 1'b1, 1'b1, 1'b1);
        req_valid_i = 1'b0;

        for (int i = 0; i < 200; i++) begin
            logic [AW-1:0] idx;
            idx = ($urandom_range(3) == 0) ? 8'($urandom) : 8'($urandom_range(7));
            do_req(idx, 1'($urandom), 1'($urandom), $urandom_range(4) == 0);
        end
        req_valid_i = 1'b0;

        @(negedge clk);
        req_valid_i   = 1'b1;
        req_index_i   = 8'h40;
        req_hit_i     = 1'b0;
        req_hit_way_i = 1'b0;
        @(negedge clk);
        req_valid_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid",
              {req_ready_o, resp_valid_o, resp_way_o, init_done_o,
               lru_wr_en_o, lru_wr_lru_o, lru_index_o},
              {6'b000010, 8'h00});
        @(negedge clk);
        check("rst_hold", {31'd0, resp_valid_o}, 0);
        rst = 1'b0;
        init_sweep();

        for (int i = 0; i < 40; i++) begin
            do_req(8'($urandom_range(3)), 1'($urandom), 1'($urandom), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
